// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the memory access unit.
//   SZ_*        access size encodings (2'd3 is reserved and always errors)
//   mau_state_t sequencer state encoding
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    DONE
  } mau_state_t;

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational little-endian lane logic for sub-word access.
//   word      in  32  memory word (read data for loads, old word for RMW)
//   off       in  2   byte offset within the word
//   size      in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   sign_ext  in  1   sign-extend extracted lane, else zero-extend
//   sub_data  in  16  store value; byte stores use bits [7:0]
//   load_val  out 32  extracted and extended load value
//   merged    out 32  word with the addressed lane replaced by sub_data
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [15:0] sub_data,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = word[{off, 3'b000} +: 8];
    half_v   = word[{off[1], 4'b0000} +: 16];
    load_val = word;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        load_val                     = {{24{sign_ext & byte_v[7]}}, byte_v};
        merged[{off, 3'b000} +: 8]   = sub_data[7:0];
      end
      SZ_HALF: begin
        load_val                     = {{16{sign_ext & half_v[15]}}, half_v};
        merged[{off[1], 4'b0000} +: 16] = sub_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle sequencer between the CPU and a unified
// instruction/data memory (combinational read, write on clock edge).
// Optional build macro: MAU_SUBWORD_EN enables byte/half loads and
// read-modify-write byte/half stores; without it only word accesses work.
//   clk, reset            clock, async active-high reset
//   req/ifetch/we/size/sign_ext/addr/wdata   request, sampled in IDLE
//   busy, done, err       status; err qualifies done
//   ir, mdr               instruction / memory data registers
//   Address, Write_data, MemRead, MemWrite, Mem_data   memory port
module mem_access_unit
  import mau_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        ifetch,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] Mem_data
);

  mau_state_t  state_q, state_d;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic        ifetch_q;
  logic        err_q;
  logic        misaligned;
  logic [31:0] load_word;
  logic        accept;

  assign accept = (state_q == IDLE) && req;

`ifdef MAU_SUBWORD_EN
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] old_q;
  logic [31:0] lane_word;
  logic [31:0] merged;

  // Fetches are always words; reserved size 3 is reported as misaligned.
  always_comb begin
    misaligned = 1'b1;
    if (ifetch) misaligned = |addr[1:0];
    else begin
      case (size)
        SZ_BYTE: misaligned = 1'b0;
        SZ_HALF: misaligned = addr[0];
        SZ_WORD: misaligned = |addr[1:0];
        default: misaligned = 1'b1;
      endcase
    end
  end

  // One lane unit serves both paths: extract from live read data in LOAD,
  // merge into the captured old word in RMW_WR.
  assign lane_word = (state_q == RMW_WR) ? old_q : Mem_data;

  mau_lane_align u_lane_align (
    .word     (lane_word),
    .off      (off_q),
    .size     (size_q),
    .sign_ext (sext_q),
    .sub_data (wdata_q[15:0]),
    .load_val (load_word),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_q  <= '0;
      size_q <= SZ_WORD;
      sext_q <= 1'b0;
      old_q  <= '0;
    end else begin
      if (accept) begin
        off_q  <= addr[1:0];
        size_q <= ifetch ? SZ_WORD : size;
        sext_q <= sign_ext;
      end
      if (state_q == RMW_RD) old_q <= Mem_data;
    end
  end
`else
  // Word-only build: anything but an aligned word is an error.
  always_comb begin
    misaligned = ifetch ? |addr[1:0] : ((size != SZ_WORD) || |addr[1:0]);
  end
  assign load_word = Mem_data;
  logic unused_sign_ext;
  assign unused_sign_ext = sign_ext;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned)             state_d = DONE;
          else if (ifetch || !we)     state_d = LOAD;
          else if (size == SZ_WORD)   state_d = STORE;
`ifdef MAU_SUBWORD_EN
          else                        state_d = RMW_RD;
`else
          else                        state_d = DONE;
`endif
        end
      end
      LOAD:    state_d = DONE;
      STORE:   state_d = DONE;
`ifdef MAU_SUBWORD_EN
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Write_data = '0;
    case (state_q)
      LOAD:  MemRead = 1'b1;
      STORE: begin
        MemWrite   = 1'b1;
        Write_data = wdata_q;
      end
`ifdef MAU_SUBWORD_EN
      RMW_RD: MemRead = 1'b1;
      RMW_WR: begin
        MemWrite   = 1'b1;
        Write_data = merged;
      end
`endif
      default: ;
    endcase
  end

  assign Address = {addr_q, 2'b00};
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = (state_q == DONE) && err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      ifetch_q <= 1'b0;
      err_q    <= 1'b0;
      ir       <= '0;
      mdr      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= addr[31:2];
        wdata_q  <= wdata;
        ifetch_q <= ifetch;
        err_q    <= misaligned;
      end
      if (state_q == LOAD) begin
        if (ifetch_q) ir  <= Mem_data;
        else          mdr <= load_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench. The driver computes each
// request's expected outcome from a word-array memory model and queues it;
// a negedge monitor pops and compares whenever done is seen.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req, ifetch, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err, MemRead, MemWrite;
  logic [31:0] ir, mdr, Address, Write_data, Mem_data;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req(req), .ifetch(ifetch), .we(we),
    .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .ir(ir), .mdr(mdr),
    .Address(Address), .Write_data(Write_data), .MemRead(MemRead),
    .MemWrite(MemWrite), .Mem_data(Mem_data)
  );

  always #5 clk = ~clk;

  // Bench memory: 64 words, preloaded through a port so it has one writer.
  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;
  assign Mem_data = mem[Address[7:2]];
  always @(posedge clk) begin
    if (pl_en)         mem[pl_idx] <= pl_val;
    else if (MemWrite) mem[Address[7:2]] <= Write_data;
  end

  typedef struct {
    logic        err;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] addr;
    int          lat;
    int          rd;
    int          wr;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [0:63];
  logic [31:0] exp_ir, exp_mdr;
  int          cyc = 0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    chk_cnt++;
    if (act === ex) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, ex, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor
  initial begin
    int   rd_c, wr_c;
    exp_t e;
    rd_c = 0;
    wr_c = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_c = 0;
        wr_c = 0;
      end else begin
        if (MemRead)  rd_c++;
        if (MemWrite) wr_c++;
        if (MemRead || MemWrite) chk("rd_wr_excl", {31'd0, MemRead & MemWrite}, 32'd0);
        if (done) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_done: got done=1 expected no pending request");
          end else begin
            e = exp_q.pop_front();
            chk("latency", cyc - e.acc, e.lat);
            chk("err", {31'd0, err}, {31'd0, e.err});
            chk("ir", ir, e.ir);
            chk("mdr", mdr, e.mdr);
            chk("address", Address, e.addr);
            chk("read_cycles", rd_c, e.rd);
            chk("write_cycles", wr_c, e.wr);
            chk("busy_at_done", {31'd0, busy}, 32'd1);
          end
          rd_c = 0;
          wr_c = 0;
        end
      end
    end
  end

  // Issue one request: model it, queue the expectation, wait for completion.
  task automatic do_req(input logic ifc, input logic w, input logic [1:0] sz,
                        input logic se, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          nb, sh;
    logic [31:0] mask, v, word;
    logic        bad, got;
    logic [5:0]  idx;
    idx  = a[7:2];
    nb   = ifc ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    bad  = (nb == 0) || ((a % nb) != 0);
`ifndef MAU_SUBWORD_EN
    if (!ifc && nb != 4) bad = 1'b1;
`endif
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    sh   = 8 * int'(a[1:0]);
    word = model_mem[idx];
    e.rd = 0;
    e.wr = 0;
    if (bad) e.lat = 1;
    else if (ifc) begin
      exp_ir = word;
      e.lat = 2; e.rd = 1;
    end else if (!w) begin
      v = (word >> sh) & mask;
      if (se && v[8 * nb - 1]) v = v | ~mask;
      exp_mdr = v;
      e.lat = 2; e.rd = 1;
    end else if (nb == 4) begin
      model_mem[idx] = wd;
      e.lat = 2; e.wr = 1;
    end else begin
      model_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      e.lat = 3; e.rd = 1; e.wr = 1;
    end
    e.err  = bad;
    e.ir   = exp_ir;
    e.mdr  = exp_mdr;
    e.addr = a & 32'hFFFF_FFFC;
    e.acc  = cyc;
    exp_q.push_back(e);
    ifetch = ifc; we = w; size = sz; sign_ext = se; addr = a; wdata = wd;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    ifetch = $urandom; we = $urandom; size = 2'($urandom); addr = $urandom; wdata = $urandom;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk_cnt++;
      $display("FAIL done_timeout: got no done within 8 cycles expected done for addr %h", a);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mem_compare(input string nm);
    int bad_words;
    bad_words = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== model_mem[i]) bad_words++;
    chk(nm, bad_words, 0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; ifetch = 1'b0; we = 1'b0; size = SZ_WORD;
    sign_ext = 1'b0; addr = '0; wdata = '0;
    pl_en = 1'b1; pl_idx = '0; pl_val = '0;
    exp_ir = '0; exp_mdr = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_enables", {30'd0, MemRead, MemWrite}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    chk("rst_address", Address, 32'd0);
    chk("rst_wdata", Write_data, 32'd0);

    for (int i = 0; i < 64; i++) begin
      pl_idx = 6'(i);
      case (i)
        0:       pl_val = 32'h2004_0005;
        16:      pl_val = 32'h1122_3344;
        32:      pl_val = 32'h80FF_1234;
        default: pl_val = $urandom;
      endcase
      model_mem[i] = pl_val;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    do_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0,  32'h0);         // fetch
    do_req(1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h83, 32'h0);         // signed byte
    do_req(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h83, 32'h0);         // unsigned byte
    do_req(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h42, 32'h0000_BEEF); // half RMW
    do_req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);         // read back
    do_req(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h06, 32'h1234_5678); // misaligned
    do_req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0);         // word load
    do_req(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h80, 32'h0);         // byte load
    do_req(1'b0, 1'b0, 2'd3,    1'b0, 32'h80, 32'h0);         // reserved size
    do_req(1'b0, 1'b1, SZ_HALF, 1'b1, 32'h41, 32'h0000_1111); // misaligned half
    mem_compare("mem_after_directed");

    // Reset in the middle of a store: no write may land.
    ifetch = 1'b0; we = 1'b1; sign_ext = 1'b0; addr = 32'h44; wdata = 32'hDEAD_BEEF;
`ifdef MAU_SUBWORD_EN
    size = SZ_BYTE;
`else
    size = SZ_WORD;
`endif
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
`ifdef MAU_SUBWORD_EN
    chk("pre_rst_memread", {31'd0, MemRead}, 32'd1);
`else
    chk("pre_rst_memwrite", {31'd0, MemWrite}, 32'd1);
`endif
    reset = 1'b1;
    #1;
    chk("mid_rst_enables", {30'd0, MemRead, MemWrite}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_ir", ir, 32'd0);
    chk("mid_rst_mdr", mdr, 32'd0);
    chk("mid_rst_address", Address, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_ir = '0;
    exp_mdr = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("post_rst_no_write", {30'd0, MemRead, MemWrite}, 32'd0);
    mem_compare("mem_after_reset");

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      logic [31:0] ra;
      ra = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) ra = ra & 32'hFC;
      do_req(($urandom_range(0, 7) == 0), 1'($urandom), 2'($urandom),
             1'($urandom), ra, $urandom);
    end
    mem_compare("mem_final");
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
